// File: rtl/acc_alu_seq_pkg.sv
// Shared definitions for the sequential accumulator ALU: default width,
// opcode encoding, FSM states and the sizing of the iteration counter.
package acc_alu_seq_pkg;

    localparam int unsigned W_DEF = 8;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_LOAD = 4'd8,
        OP_MUL  = 4'd9,
        OP_DIV  = 4'd10,
        OP_NOP  = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WRITE
    } state_e;

    // Wide enough to hold the full iteration count W, not just W-1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

    localparam int unsigned CNT_W_DEF = cnt_width(W_DEF);

endpackage

// File: rtl/acc_alu_seq_if.sv
// Request/response bundle between the accumulator controller (master)
// and the sequential ALU (slave).
interface acc_alu_seq_if #(
    parameter int unsigned W = acc_alu_seq_pkg::W_DEF
) ();

    logic         start;
    logic [3:0]   op;
    logic [W-1:0] acc_in;
    logic [W-1:0] mem_in;
    logic [W-1:0] result;
    logic         acc_we;
    logic         busy;
    logic         done;
    logic         zf;
    logic         cf;
    logic         nf;
    logic         dz;

    modport master (
        output start, op, acc_in, mem_in,
        input  result, acc_we, busy, done, zf, cf, nf, dz
    );

    modport slave (
        input  start, op, acc_in, mem_in,
        output result, acc_we, busy, done, zf, cf, nf, dz
    );

endinterface

// File: rtl/acc_alu_muldiv.sv
// Iterative multiply (shift-add) / restoring divide, one bit per step.
// A single 2W register holds {hi,lo} product or {remainder,quotient}.
module acc_alu_muldiv
    import acc_alu_seq_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned CNT_W = cnt_width(W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             is_div_i,
    input  logic             step_i,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    output logic [CNT_W-1:0] count_o,
    output logic [W-1:0]     res_o,
    output logic             ovf_o
);

    logic [2*W-1:0]   p_q, p_d, p_step;
    logic [W-1:0]     m_q, m_d;
    logic             div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [W:0] mul_sum;
    logic [W:0] div_trial;
    logic [W:0] div_diff;
    logic       div_ge;

    always_comb begin
        mul_sum   = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, m_q} : {(W+1){1'b0}});
        div_trial = p_q[2*W-1:W-1];
        div_diff  = div_trial - {1'b0, m_q};
        div_ge    = (div_trial >= {1'b0, m_q});
        if (div_q) begin
            p_step = {(div_ge ? div_diff[W-1:0] : div_trial[W-1:0]), p_q[W-2:0], div_ge};
        end else begin
            p_step = {mul_sum, p_q[W-1:1]};
        end
    end

    always_comb begin
        p_d   = p_q;
        m_d   = m_q;
        div_d = div_q;
        cnt_d = cnt_q;
        if (load_i) begin
            // Multiplier or dividend starts in the low half; the other operand is held in m.
            p_d   = {{W{1'b0}}, (is_div_i ? a_i : b_i)};
            m_d   = is_div_i ? b_i : a_i;
            div_d = is_div_i;
            cnt_d = '0;
        end else if (step_i) begin
            p_d   = p_step;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            p_q   <= p_d;
            m_q   <= m_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    // Outputs reflect the value after the step in progress, so the caller can
    // register the final result on the same edge as the last iteration.
    assign count_o = cnt_q;
    assign res_o   = p_step[W-1:0];
    assign ovf_o   = div_q ? 1'b0 : (|p_step[2*W-1:W]);

endmodule

// File: rtl/acc_alu_seq.sv
// Sequential accumulator ALU: single-cycle ops finish in one cycle,
// MUL/DIV iterate W times in acc_alu_muldiv before the write cycle.
module acc_alu_seq
    import acc_alu_seq_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    acc_alu_seq_if.slave  bus
);

    localparam int unsigned CNT_W = cnt_width(W);

    state_e       state_q, state_d;
    logic [W-1:0] result_q, result_d;
    logic         zf_q, zf_d, cf_q, cf_d, nf_q, nf_d, dz_q, dz_d;
    logic         acc_we_q, acc_we_d;
    logic         divz_q, divz_d;

    logic [W:0]       add_w, sub_w;
    logic [W-1:0]     alu_res;
    logic             alu_cf;
    logic             is_alu_op, is_iter_op;
    logic             md_load, md_step;
    logic [CNT_W-1:0] md_count;
    logic [W-1:0]     md_res;
    logic             md_ovf;

    acc_alu_muldiv #(.W(W), .CNT_W(CNT_W)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (md_load),
        .is_div_i (bus.op == OP_DIV),
        .step_i   (md_step),
        .a_i      (bus.acc_in),
        .b_i      (bus.mem_in),
        .count_o  (md_count),
        .res_o    (md_res),
        .ovf_o    (md_ovf)
    );

    always_comb begin
        add_w   = {1'b0, bus.acc_in} + {1'b0, bus.mem_in};
        sub_w   = {1'b0, bus.acc_in} - {1'b0, bus.mem_in};
        alu_res = '0;
        alu_cf  = 1'b0;
        case (bus.op)
            OP_ADD:  begin alu_res = add_w[W-1:0]; alu_cf = add_w[W]; end
            OP_SUB:  begin alu_res = sub_w[W-1:0]; alu_cf = sub_w[W]; end
            OP_AND:  alu_res = bus.acc_in & bus.mem_in;
            OP_OR:   alu_res = bus.acc_in | bus.mem_in;
            OP_XOR:  alu_res = bus.acc_in ^ bus.mem_in;
            OP_NOT:  alu_res = ~bus.acc_in;
            OP_SHL:  begin alu_res = {bus.acc_in[W-2:0], 1'b0}; alu_cf = bus.acc_in[W-1]; end
            OP_SHR:  begin alu_res = {1'b0, bus.acc_in[W-1:1]}; alu_cf = bus.acc_in[0]; end
            OP_LOAD: alu_res = bus.mem_in;
            default: begin alu_res = '0; alu_cf = 1'b0; end
        endcase
    end

    assign is_alu_op  = (bus.op <= OP_LOAD);
    assign is_iter_op = (bus.op == OP_MUL) || (bus.op == OP_DIV);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zf_d     = zf_q;
        cf_d     = cf_q;
        nf_d     = nf_q;
        dz_d     = dz_q;
        acc_we_d = 1'b0;
        divz_d   = divz_q;
        md_load  = 1'b0;
        md_step  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (is_iter_op) begin
                        md_load = 1'b1;
                        divz_d  = (bus.op == OP_DIV) && (bus.mem_in == '0);
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_WRITE;
                        if (is_alu_op) begin
                            result_d = alu_res;
                            cf_d     = alu_cf;
                            zf_d     = (alu_res == '0);
                            nf_d     = alu_res[W-1];
                            dz_d     = 1'b0;
                            acc_we_d = 1'b1;
                        end
                    end
                end
            end
            ST_EXEC: begin
                md_step = 1'b1;
                if (md_count == CNT_W'(W - 1)) begin
                    result_d = md_res;
                    cf_d     = md_ovf;
                    zf_d     = (md_res == '0);
                    nf_d     = md_res[W-1];
                    dz_d     = divz_q;
                    acc_we_d = 1'b1;
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zf_q     <= 1'b0;
            cf_q     <= 1'b0;
            nf_q     <= 1'b0;
            dz_q     <= 1'b0;
            acc_we_q <= 1'b0;
            divz_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zf_q     <= zf_d;
            cf_q     <= cf_d;
            nf_q     <= nf_d;
            dz_q     <= dz_d;
            acc_we_q <= acc_we_d;
            divz_q   <= divz_d;
        end
    end

    assign bus.result = result_q;
    assign bus.zf     = zf_q;
    assign bus.cf     = cf_q;
    assign bus.nf     = nf_q;
    assign bus.dz     = dz_q;
    assign bus.acc_we = acc_we_q;
    assign bus.done   = (state_q == ST_WRITE);
    assign bus.busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_acc_alu_seq.sv
// Directed, table-driven bench for acc_alu_seq with hand-computed expectations
// plus explicit reset-abort and restart sequences.
module tb_acc_alu_seq;
    import acc_alu_seq_pkg::*;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    acc_alu_seq_if #(.W(W)) bus ();

    acc_alu_seq #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  res;
        logic        cf;
        logic        zf;
        logic        nf;
        logic        dz;
        logic        we;
        int unsigned lat;
        int unsigned poke;
    } vec_t;

    vec_t vecs [20];

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Called at a negedge; pulses start, then waits (bounded) for done.
    // A nonzero poke drives a conflicting SUB request on that cycle after acceptance.
    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int unsigned poke, output int unsigned lat);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.acc_in = a;
        bus.mem_in = b;
        @(posedge clk);
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            lat++;
            bus.start  = 1'b0;
            bus.acc_in = ~a;
            bus.mem_in = ~b;
            if (lat == poke) begin
                bus.start  = 1'b1;
                bus.op     = OP_SUB;
                bus.acc_in = 8'h00;
                bus.mem_in = 8'h01;
            end
            if (bus.done === 1'b1) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned lat;
        logic        seen_we;

        //            op       a      b      res    cf    zf    nf    dz    we   lat poke
        vecs[0]  = '{OP_ADD,  8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1};
        vecs[1]  = '{OP_SUB,  8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0};
        vecs[2]  = '{OP_SUB,  8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0};
        vecs[3]  = '{OP_AND,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0};
        vecs[4]  = '{OP_OR,   8'h0F, 8'h80, 8'h8F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0};
        vecs[5]  = '{OP_XOR,  8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0};
        vecs[6]  = '{OP_NOT,  8'h55, 8'h00, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0};
        vecs[7]  = '{OP_SHL,  8'h81, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0};
        vecs[8]  = '{OP_SHR,  8'h81, 8'h00, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0};
        vecs[9]  = '{OP_LOAD, 8'h00, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0};
        vecs[10] = '{OP_MUL,  8'h10, 8'h11, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9, 3};
        vecs[11] = '{OP_MUL,  8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9, 0};
        vecs[12] = '{OP_DIV,  8'hC8, 8'h07, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9, 0};
        vecs[13] = '{OP_DIV,  8'h09, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 9, 0};
        vecs[14] = '{4'hF,    8'h12, 8'h34, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0};
        vecs[15] = '{OP_ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0};
        vecs[16] = '{4'hB,    8'h56, 8'h78, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0};
        vecs[17] = '{OP_SHL,  8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0};
        vecs[18] = '{OP_DIV,  8'h05, 8'h07, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9, 0};
        vecs[19] = '{OP_ADD,  8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0};

        bus.start  = 1'b0;
        bus.op     = 4'h0;
        bus.acc_in = '0;
        bus.mem_in = '0;

        #2;
        chk("rst_result", 32'(bus.result), 32'h0);
        chk("rst_flags",  32'({bus.zf, bus.cf, bus.nf, bus.dz}), 32'h0);
        chk("rst_ctrl",   32'({bus.done, bus.busy, bus.acc_we}), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].poke, lat);
            chk($sformatf("v%0d_lat", i),    32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_result", i), 32'(bus.result), 32'(vecs[i].res));
            chk($sformatf("v%0d_flags", i),  32'({bus.zf, bus.cf, bus.nf, bus.dz}),
                32'({vecs[i].zf, vecs[i].cf, vecs[i].nf, vecs[i].dz}));
            chk($sformatf("v%0d_we", i),     32'(bus.acc_we), 32'(vecs[i].we));
            chk($sformatf("v%0d_busy", i),   32'(bus.busy), 32'h1);
            @(negedge clk);
            bus.start = 1'b0;
            chk($sformatf("v%0d_idle", i),   32'({bus.done, bus.busy, bus.acc_we}), 32'h0);
            chk($sformatf("v%0d_hold", i),   32'(bus.result), 32'(vecs[i].res));
        end

        // Reset asserted in the fourth EXEC cycle of a multiply.
        bus.start  = 1'b1;
        bus.op     = OP_MUL;
        bus.acc_in = 8'h10;
        bus.mem_in = 8'h11;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("exec_busy", 32'(bus.busy), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_result", 32'(bus.result), 32'h0);
        chk("abort_flags",  32'({bus.zf, bus.cf, bus.nf, bus.dz}), 32'h0);
        chk("abort_ctrl",   32'({bus.done, bus.busy, bus.acc_we}), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_we = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.acc_we === 1'b1 || bus.done === 1'b1) seen_we = 1'b1;
        end
        chk("abort_no_we", 32'(seen_we), 32'h0);

        // Start presented together with reset release is taken on the first edge.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_ADD, 8'h01, 8'h02, 0, lat);
        chk("restart_lat",    32'(lat), 32'h1);
        chk("restart_result", 32'(bus.result), 32'h03);
        chk("restart_we",     32'(bus.acc_we), 32'h1);
        @(negedge clk);
        chk("restart_idle",   32'({bus.done, bus.busy, bus.acc_we}), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/acc_alu_seq.md
ACC_ALU_SEQ -- requirements
Module: acc_alu_seq

Interface
REQ-001 Parameter W, default 8, data width of operands and result.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request one operation; sampled only in IDLE.
REQ-005 op  input  4  opcode, latched at accepted start.
REQ-006 acc_in  input  W  current accumulator value (operand A), latched at accepted start.
REQ-007 mem_in  input  W  memory/immediate operand (operand B), latched at accepted start.
REQ-008 result  output  W  registered result driven to the accumulator write port.
REQ-009 acc_we  output  1  one-cycle accumulator write strobe.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 zf, cf, nf, dz  output  1 each  zero, carry/borrow/overflow, negative (result MSB), divide-by-zero flags.

Function
REQ-013 Opcodes SHALL be: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A, 7 SHR A (logical), 8 LOAD B, 9 MUL, 10 DIV (A/B); 11-15 NOP.
REQ-014 FSM states SHALL be IDLE, EXEC, WRITE; IDLE->WRITE on start with single-cycle op or NOP; IDLE->EXEC on start with MUL/DIV; EXEC->WRITE after exactly W iterations; WRITE->IDLE unconditionally.
REQ-015 done SHALL be high exactly during WRITE: 1 cycle after accepting edge for single-cycle ops, W+1 cycles after for MUL/DIV.
REQ-016 acc_we SHALL equal done except for NOP, where acc_we stays 0 and result/flags hold previous values.
REQ-017 result and flags SHALL be stable throughout WRITE and hold until the next WRITE.
REQ-018 ADD/SUB SHALL compute in W+1 bits; cf = carry-out (ADD) or borrow (SUB); SHL cf = A[W-1]; SHR cf = A[0]; logic ops, NOT and LOAD clear cf.
REQ-019 MUL SHALL be iterative shift-add, one bit per cycle; result = low W bits of product; cf = 1 iff high W bits nonzero.
REQ-020 DIV SHALL be restoring division, one quotient bit per cycle; result = quotient; cf = 0.
REQ-021 DIV with B = 0 SHALL still take W+1 cycles, give result all-ones, dz = 1; dz = 0 for every other op.
REQ-022 zf = (result == 0), nf = result[W-1], updated only in WRITE for non-NOP ops.
REQ-023 start while busy SHALL be ignored with no queuing; operand/op input changes while busy SHALL not affect the operation.
REQ-024 start asserted in the WRITE cycle SHALL be ignored; earliest next acceptance is the following IDLE cycle.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, result = 0, all flags 0, acc_we = 0, done = 0, busy = 0, iteration counter 0.
REQ-026 Reset during EXEC or WRITE SHALL abort the operation with no acc_we pulse after release.
REQ-027 First start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-028 Shared package SHALL hold W default, opcode constants, FSM state encoding and iteration-count width ($clog2(W)+1).
REQ-029 The iterative multiply/divide datapath SHALL be a sub-module acc_alu_muldiv (load, step, count, product/quotient outputs); single-cycle ops stay in acc_alu_seq.
REQ-030 acc_we SHALL be a flop output so the downstream accumulator, capturing on the falling edge, sees a glitch-free strobe.

Verification
REQ-031 ADD: A=8'hF0, B=8'h20, start one cycle -> next cycle done=acc_we=1, result=8'h10, cf=1, zf=0, busy high for 1 cycle.
REQ-032 SUB: A=8'h05, B=8'h05 -> result=8'h00, zf=1, cf=0; A=8'h03, B=8'h05 -> result=8'hFE, cf=1, nf=1.
REQ-033 MUL: A=8'h10, B=8'h11 -> done exactly 9 cycles after start, result=8'h10, cf=1; second start pulsed mid-EXEC ignored.
REQ-034 DIV: A=8'd200, B=8'd7 -> result=8'd28 after 9 cycles; A=8'd9, B=0 -> result=8'hFF, dz=1, acc_we=1.
REQ-035 rst_n low at EXEC cycle 4 of MUL -> outputs 0 at once, no acc_we after release, next ADD start accepted on first edge.
REQ-036 NOP op=4'hF -> done=1 one cycle later, acc_we=0, result and flags unchanged from prior operation.
